// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants, coordinate type,
// registered output bundle and axis-total helper.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic   hsync;
    logic   vsync;
    logic   de;
    coord_t x;
    coord_t y;
    logic   line_start;
    logic   frame_start;
  } vga_out_t;

  localparam vga_out_t VGA_OUT_IDLE = '{
    hsync:       1'b1,
    vsync:       1'b1,
    de:          1'b0,
    x:           '0,
    y:           '0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  function automatic int unsigned axis_total(
    input int unsigned active,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_ctr.sv
// One timing axis: wrap counter with step enable and synchronous clear, plus
// combinational terminal, active-region and sync-region flags decoded from the count.
module vga_axis_ctr
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL    = 800,
  parameter int unsigned ACTIVE   = 640,
  parameter int unsigned SYNC_BEG = 656,
  parameter int unsigned SYNC_END = 752
) (
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   step_i,
  input  logic   clr_i,
  output coord_t cnt_o,
  output logic   wrap_o,
  output logic   active_o,
  output logic   sync_o
);

  localparam coord_t C_LAST     = coord_t'(TOTAL - 1);
  localparam coord_t C_ACTIVE   = coord_t'(ACTIVE);
  localparam coord_t C_SYNC_BEG = coord_t'(SYNC_BEG);
  localparam coord_t C_SYNC_END = coord_t'(SYNC_END);

  coord_t r_cnt;
  logic   w_last;

  assign w_last = (r_cnt == C_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (step_i) begin
      r_cnt <= w_last ? '0 : r_cnt + coord_t'(1);
    end
  end

  assign cnt_o    = r_cnt;
  assign wrap_o   = w_last;
  assign active_o = (r_cnt < C_ACTIVE);
  assign sync_o   = (r_cnt >= C_SYNC_BEG) && (r_cnt < C_SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V axis counters gated by en_i, with every
// output registered one cycle after the counter state it describes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       de_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       line_start_o,
  output logic       frame_start_o
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic     w_clr;
  logic     w_v_step;
  coord_t   w_h_cnt;
  coord_t   w_v_cnt;
  logic     w_h_wrap;
  logic     w_h_act;
  logic     w_h_sync;
  logic     w_v_act;
  logic     w_v_sync;
  logic     w_unused_v_wrap;
  vga_out_t w_next;
  vga_out_t r_out;

  assign w_clr    = ~en_i;
  assign w_v_step = en_i & w_h_wrap;

  vga_axis_ctr #(
    .TOTAL    (H_TOTAL),
    .ACTIVE   (H_ACTIVE),
    .SYNC_BEG (H_ACTIVE + H_FP),
    .SYNC_END (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_ctr (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .step_i   (en_i),
    .clr_i    (w_clr),
    .cnt_o    (w_h_cnt),
    .wrap_o   (w_h_wrap),
    .active_o (w_h_act),
    .sync_o   (w_h_sync)
  );

  vga_axis_ctr #(
    .TOTAL    (V_TOTAL),
    .ACTIVE   (V_ACTIVE),
    .SYNC_BEG (V_ACTIVE + V_FP),
    .SYNC_END (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_ctr (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .step_i   (w_v_step),
    .clr_i    (w_clr),
    .cnt_o    (w_v_cnt),
    .wrap_o   (w_unused_v_wrap),
    .active_o (w_v_act),
    .sync_o   (w_v_sync)
  );

  // Decode from the current counts; the register below gives the one-cycle latency.
  always_comb begin
    w_next = VGA_OUT_IDLE;
    if (en_i) begin
      w_next.de          = w_h_act & w_v_act;
      w_next.hsync       = ~w_h_sync;
      w_next.vsync       = ~w_v_sync;
      w_next.x           = (w_h_act & w_v_act) ? w_h_cnt : '0;
      w_next.y           = (w_h_act & w_v_act) ? w_v_cnt : '0;
      w_next.line_start  = (w_h_cnt == '0) & w_v_act;
      w_next.frame_start = (w_h_cnt == '0) & (w_v_cnt == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_out <= VGA_OUT_IDLE;
    end else begin
      r_out <= w_next;
    end
  end

  assign hsync_o       = r_out.hsync;
  assign vsync_o       = r_out.vsync;
  assign de_o          = r_out.de;
  assign x_o           = r_out.x;
  assign y_o           = r_out.y;
  assign line_start_o  = r_out.line_start;
  assign frame_start_o = r_out.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen with a reduced raster (32x20 total)
// so whole frames, enable drops and async resets fit in a short run.
module tb_vga_timing_gen;

  localparam int HA = 16;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 6;
  localparam int VA = 12;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       hsync, vsync, de, line_start, frame_start;
  logic [9:0] x, y;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 0;

  // Reference state: raster position the DUT counters should hold, and the
  // output vector expected after the most recent edge.
  int          mh = 0;
  int          mv = 0;
  logic [24:0] exp_vec = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .en_i          (en),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .de_o          (de),
    .x_o           (x),
    .y_o           (y),
    .line_start_o  (line_start),
    .frame_start_o (frame_start)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [24:0] idle_vec();
    return {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
  endfunction

  function automatic logic [24:0] raster_vec(input int h, input int v);
    logic vis;
    logic [9:0] xv, yv;
    vis = (h < HA) && (v < VA);
    xv  = vis ? 10'(h) : 10'd0;
    yv  = vis ? 10'(v) : 10'd0;
    return {!(h >= HA + HF && h < HA + HF + HS),
            !(v >= VA + VF && v < VA + VF + VS),
            vis, xv, yv,
            (h == 0) && (v < VA),
            (h == 0) && (v == 0)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_vec = idle_vec();
      mh = 0;
      mv = 0;
    end else if (!en) begin
      exp_vec = idle_vec();
      mh = 0;
      mv = 0;
    end else begin
      exp_vec = raster_vec(mh, mv);
      mh = (mh + 1) % HT;
      if (mh == 0) mv = (mv + 1) % VT;
    end
  end

  function automatic logic [24:0] dut_vec();
    return {hsync, vsync, de, x, y, line_start, frame_start};
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  int de_cnt, ls_cnt, vs_lo, hs_lo, fs_cnt;

  initial begin
    rst_n = 0;
    en    = 0;

    fork
      forever begin
        @(negedge clk);
        if (chk_on) begin
          n_checks++;
          if (dut_vec() !== exp_vec) begin
            n_errors++;
            $display("FAIL cycle_model t=%0t got hs%b vs%b de%b x%0d y%0d ls%b fs%b expected hs%b vs%b de%b x%0d y%0d ls%b fs%b",
                     $time, hsync, vsync, de, x, y, line_start, frame_start,
                     exp_vec[24], exp_vec[23], exp_vec[22], exp_vec[21:12],
                     exp_vec[11:2], exp_vec[1], exp_vec[0]);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk_on = 1;
    chk("reset_idle", int'(dut_vec()), int'(idle_vec()));

    // Release reset with enable already high: first output is pixel (0,0).
    rst_n = 1;
    en    = 1;
    @(negedge clk);
    chk("first_frame_start", frame_start, 1);
    chk("first_de", de, 1);
    chk("first_xy", int'({x, y}), 0);

    de_cnt = 0; ls_cnt = 0; vs_lo = 0; hs_lo = 0; fs_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      if (i > 0) @(negedge clk);
      de_cnt += int'(de);
      ls_cnt += int'(line_start);
      vs_lo  += int'(!vsync);
      hs_lo  += int'(!hsync);
      fs_cnt += int'(frame_start);
      if (i == 15)  chk("x_last_visible", int'(x), 15);
      if (i == 16)  chk("de_falls", de, 0);
      if (i == 19)  chk("hsync_before", hsync, 1);
      if (i == 20)  chk("hsync_begin", hsync, 0);
      if (i == 26)  chk("hsync_end", hsync, 1);
      if (i == 32)  chk("y_line1", int'(y), 1);
      if (i == 447) chk("vsync_before", vsync, 1);
      if (i == 448) chk("vsync_begin", vsync, 0);
      if (i == 512) chk("vsync_end", vsync, 1);
    end
    chk("frame_de_cycles", de_cnt, 192);
    chk("frame_line_starts", ls_cnt, 12);
    chk("frame_vsync_low", vs_lo, 64);
    chk("frame_hsync_low", hs_lo, 120);
    chk("frame_starts_in_frame", fs_cnt, 1);
    @(negedge clk);
    chk("frame_period", frame_start, 1);

    // Enable drop inside the visible area, held low for five cycles.
    begin
      int k;
      for (k = 0; k < 2000 && !(mh == 10 && mv == 5); k++) @(negedge clk);
      chk("reach_h10_v5", int'(mh == 10 && mv == 5), 1);
    end
    en = 0;
    @(negedge clk);
    chk("en_drop_idle", int'(dut_vec()), int'(idle_vec()));
    repeat (4) @(negedge clk);
    en = 1;
    @(negedge clk);
    chk("en_rise_frame_start", frame_start, 1);

    // Randomised enable activity with occasional asynchronous reset pulses.
    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 999);
      if (r < 4) begin
        #3 rst_n = 0;
        #1 chk("async_reset_idle", int'(dut_vec()), int'(idle_vec()));
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #2 rst_n = 1;
      end else if (r < 30) begin
        en = 0;
      end else if (r < 300) begin
        en = 1;
      end
    end

    // Clean run across at least one full frame wrap (h=last, v=last -> 0,0).
    en = 1;
    repeat (2 * HT * VT) @(negedge clk);

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, the number of visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, the horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, the hsync pulse width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, the horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, the number of visible lines.
REQ-006 The block SHALL have parameters V_FP, default 10; V_SYNC, default 2; and V_BP, default 33, all in lines.
REQ-007 clk_i  input  1  pixel clock (25.125 MHz PLL global output); the only clock.
REQ-008 rst_n_i  input  1  reset; asynchronous, active-low.
REQ-009 en_i  input  1  run enable, driven by PLL lock.
REQ-010 hsync_o  output  1  horizontal sync, active-low.
REQ-011 vsync_o  output  1  vertical sync, active-low.
REQ-012 de_o  output  1  data enable; high during the visible region.
REQ-013 x_o  output  10  visible pixel column.
REQ-014 y_o  output  10  visible line number.
REQ-015 line_start_o  output  1  one-cycle pulse at the first pixel of each visible line.
REQ-016 frame_start_o  output  1  one-cycle pulse at pixel (0,0) of each frame.

Function
REQ-017 Internal h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800), and SHALL wrap to 0.
REQ-018 Internal v_cnt SHALL advance by one only when h_cnt wraps, and SHALL count 0..V_TOTAL-1 (default 525), wrapping to 0.
REQ-019 When h_cnt wraps and v_cnt = V_TOTAL-1 in the same cycle, both counters SHALL be 0 in the next cycle.
REQ-020 The counters SHALL advance only in cycles where en_i=1.
REQ-021 Any cycle with en_i=0 SHALL synchronously clear both counters to 0 and force all outputs to their idle values on the next edge.
REQ-022 Idle values: hsync_o=1, vsync_o=1, de_o=0, x_o=0, y_o=0, line_start_o=0, frame_start_o=0.
REQ-023 All outputs SHALL be registered with exactly one cycle of latency; outputs in cycle n+1 SHALL reflect the counter values of cycle n.
REQ-024 de_o SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-025 hsync_o SHALL be 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (default 656..751).
REQ-026 vsync_o SHALL be 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (default 490..491); it depends only on v_cnt.
REQ-027 x_o SHALL equal h_cnt and y_o SHALL equal v_cnt when de_o=1; both SHALL be 0 otherwise.
REQ-028 line_start_o SHALL be 1 iff h_cnt=0 and v_cnt<V_ACTIVE.
REQ-029 frame_start_o SHALL be 1 iff h_cnt=0 and v_cnt=0; it therefore coincides with a line_start_o pulse.
REQ-030 After en_i rises, the first output cycle SHALL show frame_start_o=1, de_o=1, x_o=0, y_o=0.
REQ-031 All counter and compare arithmetic SHALL be 10-bit unsigned.
REQ-032 Parameter sets with H_TOTAL>1024 or V_TOTAL>1024 are unsupported.

Reset
REQ-033 rst_n_i=0 SHALL asynchronously clear both counters to 0 and drive all outputs to their idle values.
REQ-034 A reset asserted mid-frame SHALL abort the frame; after release, operation SHALL proceed as in REQ-030 once en_i=1.

Structure
REQ-035 The default timing constants, H_TOTAL/V_TOTAL derivation helpers and the 10-bit coordinate type SHALL live in shared package vga_timing_pkg.
REQ-036 The block SHALL instantiate sub-module vga_axis_ctr twice, once for H and once for V.
REQ-037 vga_axis_ctr SHALL provide a parameterised wrap counter with step enable, synchronous clear, wrap flag, active flag and sync flag.

Verification
REQ-038 Reset released with en_i=1 -> frame_start_o pulses every 420000 cycles, and line_start_o pulses 480 times per frame at 800-cycle spacing.
REQ-039 Count within one line -> de_o high for 640 cycles, hsync_o low for 96 cycles beginning 16 cycles after de_o falls, x_o running 0..639.
REQ-040 Count within one frame -> vsync_o low for exactly 1600 cycles (lines 490-491), y_o running 0..479, de_o never high on lines 480-524.
REQ-041 en_i dropped at h=300, v=200 for 5 cycles, then raised -> outputs idle on the next edge, and frame_start_o=1 one cycle after en_i rises.
REQ-042 rst_n_i pulsed low asynchronously mid-line -> outputs idle immediately with no clock edge, then restart from (0,0) after release.
REQ-043 Wrap boundary (h=799, v=524) -> the next cycle shows frame_start_o=1 with no glitch on vsync_o.
